multicycle_main_control: RTL and testbench

//  Main control FSM for the multi-cycle RV32 core. Sequences the shared ALU, memory port, IR, PC and

---
 rtl/multicycle_main_control.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RV32 core (R-type, LW, SW, BEQ) with illegal-opcode and memory-timeout traps.
// Optional PERF_CNT_EN adds cycle/instruction counters; without it both counter outputs are tied to 0.
module multicycle_main_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic             instr_done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_ERR      = 4'd9
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_err_code;
  logic [1:0]        w_err_code_next;
  logic [WAIT_W-1:0] r_wait;
  logic              w_wait_state;
  logic              w_timeout;

  // The wait counter holds the number of earlier mem_ready-low cycles in this state,
  // so the current low cycle is the MEM_TIMEOUT-th one when it equals MEM_TIMEOUT-1.
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout    = (MEM_TIMEOUT != 0) && w_wait_state && !mem_ready &&
                        (int'(r_wait) == MEM_TIMEOUT - 1);
  assign state_o      = r_state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_err_code <= ERR_NONE;
      r_wait     <= '0;
    end else begin
      r_state    <= w_next_state;
      r_err_code <= w_err_code_next;
      if (w_next_state != r_state)
        r_wait <= '0;
      else if (w_wait_state && !mem_ready)
        r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_err_code_next = r_err_code;
    pc_write        = 1'b0;
    pc_src          = 1'b0;
    ir_write        = 1'b0;
    iord            = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    reg_write       = 1'b0;
    mem_to_reg      = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    aluop           = 2'b00;
    instr_done      = 1'b0;
    err             = 1'b0;
    err_code        = ERR_NONE;

    if (!rst) begin
      err_code = r_err_code;
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            w_next_state = S_DECODE;
          end else if (w_timeout) begin
            w_next_state    = S_ERR;
            w_err_code_next = ERR_TIMEOUT;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b10;
          case (opcode)
            OP_LOAD, OP_STORE: w_next_state = S_MEM_ADDR;
            OP_RTYPE:          w_next_state = S_EXEC_R;
            OP_BRANCH:         w_next_state = S_BRANCH;
            default: begin
              w_next_state    = S_ERR;
              w_err_code_next = ERR_ILLEGAL;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          w_next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) begin
            w_next_state = S_MEM_WB;
          end else if (w_timeout) begin
            w_next_state    = S_ERR;
            w_err_code_next = ERR_TIMEOUT;
          end
        end
        S_MEM_WB: begin
          reg_write    = 1'b1;
          mem_to_reg   = 1'b1;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) begin
            instr_done   = 1'b1;
            w_next_state = S_FETCH;
          end else if (w_timeout) begin
            w_next_state    = S_ERR;
            w_err_code_next = ERR_TIMEOUT;
          end
        end
        S_EXEC_R: begin
          alu_src_a    = 1'b1;
          aluop        = 2'b10;
          w_next_state = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write    = 1'b1;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a    = 1'b1;
          aluop        = 2'b01;
          pc_src       = 1'b1;
          pc_write     = zero;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end
        S_ERR: begin
          err = 1'b1;
        end
        default: begin
          w_next_state    = S_ERR;
          w_err_code_next = ERR_ILLEGAL;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_state != S_ERR)
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (instr_done)
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt = rst ? '0 : r_cycle_cnt;
  assign instr_cnt = rst ? '0 : r_instr_cnt;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: directed vectors, corner sequences and a
// randomized run against an instruction-level step-queue model.
module tb_multicycle_main_control;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_RD = 3, ST_MEM_WB = 4;
  localparam int ST_MEM_WR = 5, ST_EXEC_R = 6, ST_ALU_WB = 7, ST_BRANCH = 8, ST_ERR = 9;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst, zero, mem_ready;
  logic [6:0]    opcode;
  logic          pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg;
  logic          alu_src_a, instr_done, err;
  logic [1:0]    alu_src_b, aluop, err_code;
  logic [3:0]    state_o;
  logic [CW-1:0] cycle_cnt, instr_cnt;

  always #5 clk = ~clk;

  multicycle_main_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .instr_done(instr_done),
    .err(err), .err_code(err_code), .state_o(state_o), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       instr_done;
    logic       err;
    logic [1:0] err_code;
  } ctrl_t;

  ctrl_t act;
  assign act = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
                alu_src_a, alu_src_b, aluop, instr_done, err, err_code};

  typedef struct {
    logic [6:0] op;
    logic       z;
    int         stall;
    int         cycles;
    logic       regw;
    logic       pcw;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of the steps still to run for the current instruction; front = current step.
  int m_q[$];
  int m_wait, m_err, m_cyc, m_icnt;
  bit m_known = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic ctrl_t exp_ctrl(input int step, input logic mr, input logic z, input int code);
    ctrl_t c;
    c = '0;
    case (step)
      ST_FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      ST_DECODE:   c.alu_src_b = 2'b10;
      ST_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      ST_MEM_RD:   begin c.mem_read = 1; c.iord = 1; end
      ST_MEM_WB:   begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      ST_MEM_WR:   begin c.mem_write = 1; c.iord = 1; c.instr_done = mr; end
      ST_EXEC_R:   begin c.alu_src_a = 1; c.aluop = 2'b10; end
      ST_ALU_WB:   begin c.reg_write = 1; c.instr_done = 1; end
      ST_BRANCH:   begin c.alu_src_a = 1; c.aluop = 2'b01; c.pc_src = 1; c.pc_write = z; c.instr_done = 1; end
      ST_ERR:      begin c.err = 1; c.err_code = code[1:0]; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  // Drive one cycle's inputs just after the falling edge, then compare against the model.
  task automatic tick(input logic r, input logic [6:0] op, input logic mr, input logic z);
    rst = r; opcode = op; mem_ready = mr; zero = z;
    #1;
    if (r) check("ctrl_in_reset", act, 32'd0);
    else   check("ctrl", act, exp_ctrl(m_q[0], mr, z, m_err));
    if (m_known) check("state", state_o, m_q[0]);
`ifdef PERF_CNT_EN
    check("cycle_cnt", cycle_cnt, r ? 0 : m_cyc);
    check("instr_cnt", instr_cnt, r ? 0 : m_icnt);
`else
    check("cycle_cnt_tied", cycle_cnt, 0);
    check("instr_cnt_tied", instr_cnt, 0);
`endif
  endtask

  // Advance the model by the cycle just checked, then move to the next falling edge.
  task automatic adv();
    int    cur;
    ctrl_t e;
    if (rst) begin
      m_q = '{ST_FETCH, ST_DECODE};
      m_wait = 0; m_err = 0; m_cyc = 0; m_icnt = 0; m_known = 1'b1;
    end else begin
      cur = m_q[0];
      e = exp_ctrl(cur, mem_ready, zero, m_err);
      if (cur != ST_ERR) m_cyc = (m_cyc + 1) % (1 << CW);
      if (e.instr_done)  m_icnt = (m_icnt + 1) % (1 << CW);
      if (cur == ST_FETCH || cur == ST_MEM_RD || cur == ST_MEM_WR) begin
        if (mem_ready) begin
          void'(m_q.pop_front());
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TO) begin m_q = '{ST_ERR}; m_err = 2; m_wait = 0; end
        end
      end else if (cur == ST_DECODE) begin
        void'(m_q.pop_front());
        case (opcode)
          OP_LW:   m_q = '{ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB};
          OP_SW:   m_q = '{ST_MEM_ADDR, ST_MEM_WR};
          OP_R:    m_q = '{ST_EXEC_R, ST_ALU_WB};
          OP_BEQ:  m_q = '{ST_BRANCH};
          default: begin m_q = '{ST_ERR}; m_err = 1; end
        endcase
      end else if (cur != ST_ERR) begin
        void'(m_q.pop_front());
      end
      if (m_q.size() == 0) m_q = '{ST_FETCH, ST_DECODE};
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    repeat (3) begin tick(1'b1, OP_R, 1'b1, 1'b0); adv(); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[7];
    int         exp_st[5];
    int         dones, ok, done_cyc, sel;
    bit         seen;
    logic       regw_a, pcw_a, r_rst;
    logic [6:0] r_op;

    vecs[0] = '{op: OP_R,   z: 1'b0, stall: 0, cycles: 4, regw: 1'b1, pcw: 1'b0};
    vecs[1] = '{op: OP_LW,  z: 1'b0, stall: 0, cycles: 5, regw: 1'b1, pcw: 1'b0};
    vecs[2] = '{op: OP_LW,  z: 1'b0, stall: 3, cycles: 8, regw: 1'b1, pcw: 1'b0};
    vecs[3] = '{op: OP_SW,  z: 1'b0, stall: 0, cycles: 4, regw: 1'b0, pcw: 1'b0};
    vecs[4] = '{op: OP_SW,  z: 1'b1, stall: 2, cycles: 6, regw: 1'b0, pcw: 1'b0};
    vecs[5] = '{op: OP_BEQ, z: 1'b1, stall: 0, cycles: 3, regw: 1'b0, pcw: 1'b1};
    vecs[6] = '{op: OP_BEQ, z: 1'b0, stall: 0, cycles: 3, regw: 1'b0, pcw: 1'b0};
    exp_st = '{0, 1, 6, 7, 0};

    rst = 1'b1; opcode = OP_R; mem_ready = 1'b1; zero = 1'b0;
    @(negedge clk);
    do_reset();

    // R-type trace at zero wait states
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, OP_R, 1'b1, 1'b0);
      check("rtype_state", state_o, exp_st[i]);
      if (i == 2) check("rtype_aluop", aluop, 2);
      if (i == 3) check("rtype_reg_write", reg_write, 1);
      dones += int'(instr_done);
      adv();
    end
    check("rtype_done_pulses", dones, 1);

    // Latency table, with optional data-memory stall cycles
    for (int v = 0; v < 7; v++) begin
      do_reset();
      seen = 1'b0; done_cyc = 0; regw_a = 1'b0; pcw_a = 1'b0;
      for (int c = 1; c <= 20 && !seen; c++) begin
        tick(1'b0, vecs[v].op, !(c >= 4 && c < 4 + vecs[v].stall), vecs[v].z);
        if (instr_done) begin
          seen = 1'b1; done_cyc = c; regw_a = reg_write; pcw_a = pc_write;
        end
        adv();
      end
      check($sformatf("vec%0d_latency", v), done_cyc, vecs[v].cycles);
      check($sformatf("vec%0d_reg_write", v), regw_a, vecs[v].regw);
      check($sformatf("vec%0d_pc_write", v), pcw_a, vecs[v].pcw);
    end

    // Illegal opcode: sticky trap until reset
    do_reset();
    tick(1'b0, OP_BAD, 1'b1, 1'b0); adv();
    tick(1'b0, OP_BAD, 1'b1, 1'b0); adv();
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, OP_BAD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (state_o == 4'd9 && err === 1'b1 && err_code === 2'b01) ok++;
      adv();
    end
    check("illegal_err_hold", ok, 20);
    do_reset();
    tick(1'b0, OP_R, 1'b1, 1'b0);
    check("illegal_reset_state", state_o, 0);
    check("illegal_reset_err", err, 0);
    adv();

    // Fetch timeout: four low cycles trap, ready on the fourth completes
    do_reset();
    for (int c = 1; c <= 4; c++) begin tick(1'b0, OP_R, 1'b0, 1'b0); adv(); end
    tick(1'b0, OP_R, 1'b1, 1'b0);
    check("timeout_state", state_o, 9);
    check("timeout_err_code", err_code, 2);
    check("timeout_err", err, 1);
    adv();
    do_reset();
    for (int c = 1; c <= 3; c++) begin tick(1'b0, OP_R, 1'b0, 1'b0); adv(); end
    tick(1'b0, OP_R, 1'b1, 1'b0); adv();
    tick(1'b0, OP_R, 1'b1, 1'b0);
    check("timeout_edge_decode", state_o, 1);
    adv();

    // Reset in the middle of a load aborts it
    do_reset();
    repeat (3) begin tick(1'b0, OP_LW, 1'b1, 1'b0); adv(); end
    tick(1'b0, OP_LW, 1'b0, 1'b0); adv();
    tick(1'b1, OP_LW, 1'b1, 1'b0);
    check("abort_state_reg", state_o, 3);
    check("abort_no_done", instr_done, 0);
    check("abort_no_read", mem_read, 0);
    adv();
    tick(1'b0, OP_LW, 1'b1, 1'b0);
    check("abort_to_fetch", state_o, 0);
    adv();

`ifdef PERF_CNT_EN
    // Six back-to-back R-types with 4-bit counters
    do_reset();
    repeat (24) begin tick(1'b0, OP_R, 1'b1, 1'b0); adv(); end
    tick(1'b0, OP_R, 1'b1, 1'b0);
    check("perf_instr_cnt", instr_cnt, 6);
    check("perf_cycle_wrap", cycle_cnt, 24 % 16);
    adv();
`endif

    // Randomized run against the model
    do_reset();
    r_op = OP_R;
    for (int i = 0; i < 3000; i++) begin
      if (m_q[0] == ST_FETCH) begin
        sel = $urandom_range(0, 19);
        if      (sel < 5)  r_op = OP_R;
        else if (sel < 10) r_op = OP_LW;
        else if (sel < 15) r_op = OP_SW;
        else if (sel < 19) r_op = OP_BEQ;
        else               r_op = 7'($urandom);
      end
      r_rst = (m_q[0] == ST_ERR && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
      tick(r_rst, r_op, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
